// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a little-endian 32-bit program image over 8N1 UART and writes it to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CELL_NUMBERS = 256,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              cpu_rst,
  output logic              frame_err,
  output logic              chk_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned WW = ADDR_W + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(CELL_NUMBERS - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t          state, state_n, home;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      sh, sh_n;
  logic [1:0]      byte_cnt, byte_n;
  logic [WW-1:0]   word_cnt, word_n;
  logic [23:0]     buf_q, buf_n;
  logic            we_n, ferr_n, load_n, set_done;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]     wdata_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      acc, acc_n;
  logic            chk_phase, phase_n, cerr_n;
`endif

  // Receiver FSM and word assembly; every register's next value is decided here
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    sh_n     = sh;
    byte_n   = byte_cnt;
    word_n   = word_cnt;
    buf_n    = buf_q;
    we_n     = 1'b0;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    ferr_n   = frame_err;
    set_done = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    acc_n    = acc;
    phase_n  = chk_phase;
    cerr_n   = chk_err;
    home     = chk_phase ? CHECK : IDLE;
`else
    home     = IDLE;
`endif
    unique case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (!rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
`endif
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? home : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = home;
          if (!rx_s) ferr_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          else if (chk_phase) begin
            state_n = DONE;
            if (sh == acc) set_done = 1'b1;
            else           cerr_n   = 1'b1;
          end
`endif
          else begin
`ifdef LOADER_CHECKSUM_EN
            acc_n = acc ^ sh;
`endif
            // Fourth byte completes the word: write it out and advance the address
            if (byte_cnt == 2'd3) begin
              we_n    = 1'b1;
              addr_n  = ADDR_W'(word_cnt);
              wdata_n = {sh, buf_q};
              byte_n  = '0;
              word_n  = word_cnt + 1'b1;
              if (word_cnt == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                state_n = CHECK;
                phase_n = 1'b1;
`else
                state_n = DONE;
`endif
              end
            end else begin
              byte_n = byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0:    buf_n[7:0]   = sh;
                2'd1:    buf_n[15:8]  = sh;
                default: buf_n[23:16] = sh;
              endcase
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
`ifndef LOADER_CHECKSUM_EN
    set_done = (state == DONE);
`endif
    load_n = load_done | set_done;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      buf_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      cpu_rst   <= 1'b1;
      frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc       <= '0;
      chk_phase <= 1'b0;
      chk_err   <= 1'b0;
`endif
    end else begin
      sync1     <= uart_rx;
      rx_s      <= sync1;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      sh        <= sh_n;
      byte_cnt  <= byte_n;
      word_cnt  <= word_n;
      buf_q     <= buf_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      load_done <= load_n;
      cpu_rst   <= ~load_n;
      frame_err <= ferr_n;
`ifdef LOADER_CHECKSUM_EN
      acc       <= acc_n;
      chk_phase <= phase_n;
      chk_err   <= cerr_n;
`endif
    end
  end

`ifndef LOADER_CHECKSUM_EN
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed scenarios plus randomized loads against a byte-level model.
module tb_uart_prog_loader;
  localparam int unsigned CPB   = 4;
  localparam int unsigned CELLS = 2;
  localparam int unsigned AW    = 1;

  typedef logic [AW+31:0] wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          load_done, cpu_rst, frame_err, chk_err;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .CELL_NUMBERS(CELLS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .load_done(load_done), .cpu_rst(cpu_rst),
    .frame_err(frame_err), .chk_err(chk_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observed write log and timing invariants
  wr_t  wq[$];
  int   cyc = 0, we_cycle = -1, ld_rise = -1, we_long = 0, inv_bad = 0;
  logic we_prev = 1'b0, ld_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      we_cycle = cyc;
    end
    if (mem_we && we_prev) we_long++;
    if (load_done && !ld_prev) ld_rise = cyc;
    if (cpu_rst !== ~load_done) inv_bad++;
    we_prev = mem_we;
    ld_prev = load_done;
  end

  // Reference model: what an ideal loader does with each whole frame
  logic [7:0] m_bytes[$];
  wr_t        exp_q[$];
  int         m_word;
  bit         m_done, m_ferr, m_cerr, m_check;
  logic [7:0] m_xor;

  function automatic void model_reset();
    m_bytes.delete(); exp_q.delete();
    m_word = 0; m_done = 0; m_ferr = 0; m_cerr = 0; m_check = 0; m_xor = 8'h00;
  endfunction

  function automatic void model_good(input logic [7:0] b);
    if (m_done || m_cerr) return;
    if (m_check) begin
      if (b == m_xor) m_done = 1; else m_cerr = 1;
      return;
    end
    m_xor = m_xor ^ b;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      exp_q.push_back({AW'(m_word), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
      m_bytes.delete();
      m_word++;
      if (m_word == CELLS) begin
`ifdef LOADER_CHECKSUM_EN
        m_check = 1;
`else
        m_done = 1;
`endif
      end
    end
  endfunction

  function automatic void model_bad();
    if (!m_done && !m_cerr) m_ferr = 1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b, input int gap);
    send_frame(b, 1'b1, gap);
    model_good(b);
  endtask

  task automatic send_bad(input logic [7:0] b);
    send_frame(b, 1'b0, 2 * CPB);
    model_bad();
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    wq.delete();
    ld_rise = -1;
    model_reset();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0)     begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0)    begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (load_done !== 1'b0)  begin n_err++; $display("FAIL reset_load_done got %b want 0", load_done); end
    n_cmp++; if (cpu_rst !== 1'b1)    begin n_err++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
    n_cmp++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (chk_err !== 1'b0)    begin n_err++; $display("FAIL reset_chk_err got %b want 0", chk_err); end
    release_reset();
    n_cmp++; if (cpu_rst !== 1'b1)    begin n_err++; $display("FAIL post_reset_cpu_rst got %b want 1", cpu_rst); end
  endtask

  task automatic test_basic_load();
    logic [7:0] img[8];
    img = '{8'h93, 8'h02, 8'h10, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00};
    apply_reset();
    release_reset();
    for (int i = 0; i < 4; i++) send_good(img[i], (i == 3) ? 2 * CPB : 0);
    n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL basic_w0_count got %0d want 1", wq.size()); end
    if (wq.size() > 0) begin
      n_cmp++; if (wq[0] !== wr_t'({1'b0, 32'h00100293})) begin n_err++; $display("FAIL basic_w0 got %h want %h", wq[0], {1'b0, 32'h00100293}); end
    end
    n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL basic_w0_load_done got %b want 0", load_done); end
    n_cmp++; if (cpu_rst !== 1'b1)   begin n_err++; $display("FAIL basic_w0_cpu_rst got %b want 1", cpu_rst); end
    for (int i = 4; i < 8; i++) send_good(img[i], (i == 7) ? 2 * CPB : 0);
    n_cmp++; if (wq.size() !== 2) begin n_err++; $display("FAIL basic_w1_count got %0d want 2", wq.size()); end
    if (wq.size() > 1) begin
      n_cmp++; if (wq[1] !== wr_t'({1'b1, 32'h00100313})) begin n_err++; $display("FAIL basic_w1 got %h want %h", wq[1], {1'b1, 32'h00100313}); end
    end
`ifdef LOADER_CHECKSUM_EN
    n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL basic_await_chk_load_done got %b want 0", load_done); end
    send_good(m_xor, 2 * CPB);
    n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL basic_chk_load_done got %b want 1", load_done); end
    n_cmp++; if (chk_err !== 1'b0)   begin n_err++; $display("FAIL basic_chk_err got %b want 0", chk_err); end
    apply_reset();
    release_reset();
    for (int i = 0; i < 8; i++) send_good(img[i], 0);
    send_good(m_xor ^ 8'h01, 2 * CPB);
    n_cmp++; if (chk_err !== 1'b1)   begin n_err++; $display("FAIL badchk_chk_err got %b want 1", chk_err); end
    n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL badchk_load_done got %b want 0", load_done); end
    n_cmp++; if (cpu_rst !== 1'b1)   begin n_err++; $display("FAIL badchk_cpu_rst got %b want 1", cpu_rst); end
`else
    n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL basic_load_done got %b want 1", load_done); end
    n_cmp++; if (cpu_rst !== 1'b0)   begin n_err++; $display("FAIL basic_cpu_rst got %b want 0", cpu_rst); end
    n_cmp++; if (ld_rise !== we_cycle + 1) begin n_err++; $display("FAIL basic_done_latency got cycle %0d want %0d", ld_rise, we_cycle + 1); end
    send_good(8'hFF, 2 * CPB);
    n_cmp++; if (wq.size() !== 2) begin n_err++; $display("FAIL basic_after_done_count got %0d want 2", wq.size()); end
`endif
  endtask

  task automatic test_frame_error();
    logic [7:0] b[4];
    apply_reset();
    release_reset();
    send_bad(8'h55);
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b want 1", frame_err); end
    n_cmp++; if (wq.size() !== 0)    begin n_err++; $display("FAIL ferr_no_write got %0d want 0", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send_good(b[i], (i == 3) ? 2 * CPB : 0);
    end
    n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL ferr_next_count got %0d want 1", wq.size()); end
    if (wq.size() > 0) begin
      n_cmp++; if (wq[0] !== wr_t'({1'b0, b[3], b[2], b[1], b[0]})) begin n_err++; $display("FAIL ferr_next_word got %h want %h", wq[0], {1'b0, b[3], b[2], b[1], b[0]}); end
    end
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky got %b want 1", frame_err); end
  endtask

  task automatic test_false_start();
    logic [7:0] b[4];
    apply_reset();
    release_reset();
    glitch();
    n_cmp++; if (wq.size() !== 0)    begin n_err++; $display("FAIL glitch_no_write got %0d want 0", wq.size()); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL glitch_frame_err got %b want 0", frame_err); end
    n_cmp++; if (chk_err !== 1'b0)   begin n_err++; $display("FAIL glitch_chk_err got %b want 0", chk_err); end
    n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL glitch_load_done got %b want 0", load_done); end
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send_good(b[i], (i == 3) ? 2 * CPB : 0);
    end
    n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL glitch_next_count got %0d want 1", wq.size()); end
    if (wq.size() > 0) begin
      n_cmp++; if (wq[0] !== wr_t'({1'b0, b[3], b[2], b[1], b[0]})) begin n_err++; $display("FAIL glitch_next_word got %h want %h", wq[0], {1'b0, b[3], b[2], b[1], b[0]}); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b[4];
    apply_reset();
    release_reset();
    send_good(8'($urandom), 0);
    send_good(8'($urandom), 0);
    send_bad(8'($urandom));
    uart_rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    apply_reset();
    n_cmp++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL midrst_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0)    begin n_err++; $display("FAIL midrst_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== '0)   begin n_err++; $display("FAIL midrst_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    n_cmp++; if (cpu_rst !== 1'b1)   begin n_err++; $display("FAIL midrst_cpu_rst got %b want 1", cpu_rst); end
    release_reset();
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send_good(b[i], (i == 3) ? 2 * CPB : 0);
    end
    n_cmp++; if (wq.size() !== 1) begin n_err++; $display("FAIL midrst_next_count got %0d want 1", wq.size()); end
    if (wq.size() > 0) begin
      n_cmp++; if (wq[0] !== wr_t'({1'b0, b[3], b[2], b[1], b[0]})) begin n_err++; $display("FAIL midrst_next_word got %h want %h", wq[0], {1'b0, b[3], b[2], b[1], b[0]}); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         ev;
    wr_t        hold;
    for (int iter = 0; iter < 6; iter++) begin
      apply_reset();
      release_reset();
      ev = 0;
      while (!(m_done || m_cerr) && ev < 40) begin
        case ($urandom_range(0, 9))
          0:       send_bad(8'($urandom));
          1:       glitch();
          default: begin
            b = 8'($urandom);
            if (m_check && $urandom_range(0, 1) == 1) b = m_xor;
            send_good(b, $urandom_range(0, CPB));
          end
        endcase
        ev++;
      end
      send_good(8'($urandom), 0);
      send_bad(8'($urandom));
      repeat (2 * CPB) @(negedge clk);
      hold = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : '0;
      n_cmp++; if (wq.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d", iter, wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        n_cmp++; if (wq[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_write%0d got %h want %h", iter, i, wq[i], exp_q[i]); end
      end
      n_cmp++; if ({mem_addr, mem_wdata} !== hold) begin n_err++; $display("FAIL rand%0d_hold got %h want %h", iter, {mem_addr, mem_wdata}, hold); end
      n_cmp++; if (frame_err !== m_ferr)  begin n_err++; $display("FAIL rand%0d_frame_err got %b want %b", iter, frame_err, m_ferr); end
      n_cmp++; if (chk_err !== m_cerr)    begin n_err++; $display("FAIL rand%0d_chk_err got %b want %b", iter, chk_err, m_cerr); end
      n_cmp++; if (load_done !== m_done)  begin n_err++; $display("FAIL rand%0d_load_done got %b want %b", iter, load_done, m_done); end
      n_cmp++; if (cpu_rst !== !m_done)   begin n_err++; $display("FAIL rand%0d_cpu_rst got %b want %b", iter, cpu_rst, !m_done); end
    end
    n_cmp++; if (we_long !== 0) begin n_err++; $display("FAIL we_pulse_width got %0d long pulses want 0", we_long); end
    n_cmp++; if (inv_bad !== 0) begin n_err++; $display("FAIL cpu_rst_vs_load_done got %0d disagreements want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_frame_error();
    test_false_start();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
